// File: rtl/msdf_to_bin.sv
// Serial MSD-first signed-digit to two's-complement converter.
// Uses on-the-fly conversion (Q/QM pair) so the result is ready on the final digit.
module msdf_to_bin #(
   parameter int TARGET_PRECISION = 16
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [2:0]                  dataInArray_0,
   input  logic                        pValidArray_0,
   output logic                        readyArray_0,
   output logic [TARGET_PRECISION:0]   dataOutArray_0,
   output logic                        validArray_0,
   input  logic                        nReadyArray_0,
   output logic                        len_err
);

   localparam int N  = TARGET_PRECISION;
   localparam int W  = N + 1;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] N_C = CW'(N);

   typedef enum logic [1:0] {ACC, PAD, OUT} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    q_q, q_d;
   logic [W-1:0]    qm_q, qm_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            len_err_q, len_err_d;
   logic [1:0]      sync_q, sync_d;

   logic            handshake;
   logic            last;
   logic            dig_pos;
   logic            dig_neg;
   logic [CW-1:0]   cnt_inc;

   // sync_q[1] holds digit acceptance off until reset release has been seen on two edges
   assign readyArray_0   = (state_q == ACC) && sync_q[1];
   assign validArray_0   = (state_q == OUT);
   assign dataOutArray_0 = q_q;
   assign len_err        = len_err_q;

   assign handshake = pValidArray_0 && readyArray_0;
   assign last      = dataInArray_0[2];
   assign dig_pos   = dataInArray_0[1] && !dataInArray_0[0];
   assign dig_neg   = !dataInArray_0[1] && dataInArray_0[0];
   assign cnt_inc   = cnt_q + CW'(1);

   always_comb begin
      sync_d    = {sync_q[0], 1'b1};
      state_d   = state_q;
      q_d       = q_q;
      qm_d      = qm_q;
      cnt_d     = cnt_q;
      len_err_d = len_err_q;
      case (state_q)
         ACC: begin
            if (handshake) begin
               cnt_d = cnt_inc;
               if (dig_pos) begin
                  q_d  = {q_q[W-2:0], 1'b1};
                  qm_d = {q_q[W-2:0], 1'b0};
               end else if (dig_neg) begin
                  q_d  = {qm_q[W-2:0], 1'b1};
                  qm_d = {qm_q[W-2:0], 1'b0};
               end else begin
                  q_d  = {q_q[W-2:0], 1'b0};
                  qm_d = {qm_q[W-2:0], 1'b1};
               end
               if (cnt_inc == N_C) begin
                  state_d   = OUT;
                  len_err_d = !last;
               end else if (last) begin
                  state_d   = PAD;
                  len_err_d = 1'b1;
               end
            end
         end
         // Zero-fill the missing low-order digits of a short word
         PAD: begin
            q_d   = {q_q[W-2:0], 1'b0};
            qm_d  = {qm_q[W-2:0], 1'b1};
            cnt_d = cnt_inc;
            if (cnt_inc == N_C) begin
               state_d = OUT;
            end
         end
         OUT: begin
            if (nReadyArray_0) begin
               state_d   = ACC;
               q_d       = '0;
               qm_d      = '1;
               cnt_d     = '0;
               len_err_d = 1'b0;
            end
         end
         default: begin
            state_d = ACC;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ACC;
         q_q       <= '0;
         qm_q      <= '1;
         cnt_q     <= '0;
         len_err_q <= 1'b0;
         sync_q    <= 2'b00;
      end else begin
         state_q   <= state_d;
         q_q       <= q_d;
         qm_q      <= qm_d;
         cnt_q     <= cnt_d;
         len_err_q <= len_err_d;
         sync_q    <= sync_d;
      end
   end

endmodule

// File: doc/msdf_to_bin.md
MSDF_TO_BIN -- requirements
Module: msdf_to_bin

Interface
REQ-001 Parameter TARGET_PRECISION, default 16, sets digits per word (N); SHALL be >= 2.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 dataInArray_0  input  3  bit[2] = last flag; bits[1:0] = signed digit, MSD first.
REQ-005 pValidArray_0  input  1  upstream digit valid.
REQ-006 readyArray_0  output  1  block accepts a digit this cycle.
REQ-007 dataOutArray_0  output  N+1  two's-complement result word; value = dataOutArray_0 * 2^-N.
REQ-008 validArray_0  output  1  result word valid.
REQ-009 nReadyArray_0  input  1  downstream accepts the result.
REQ-010 len_err  output  1  stream length error for the word currently presented; SHALL be valid only while validArray_0=1.

Function
REQ-011 Digit decode SHALL be: value = bit[1] - bit[0]; 2'b10 = +1, 2'b01 = -1, 2'b00 and 2'b11 = 0.
REQ-012 A digit handshake SHALL occur when pValidArray_0=1 and readyArray_0=1 on a rising edge.
REQ-013 Conversion SHALL be on-the-fly with N+1-bit registers Q and QM, where Q starts at 0 and QM starts at all-ones.
REQ-014 Per accepted digit d, Q and QM SHALL update as follows:
- d=+1: Q<=2Q+1, QM<=2Q
- d=0: Q<=2Q, QM<=2QM+1
- d=-1: Q<=2QM+1, QM<=2QM
- All arithmetic SHALL be modulo 2^(N+1).
REQ-015 The FSM SHALL have three states: ACC (accept digits), PAD (zero-fill), OUT (present result).
REQ-016 A digit counter cnt (0..N) SHALL increment on every digit handshake and on every PAD cycle.
REQ-017 readyArray_0 SHALL be 1 only in ACC; it SHALL be a combinational function of state only.
REQ-018 ACC -> OUT SHALL occur on the handshake of the N-th digit.
- len_err SHALL be set to NOT last on that digit.
REQ-019 ACC -> PAD SHALL occur on a handshake with last=1 when cnt+1 < N.
- len_err SHALL be set to 1.
REQ-020 In PAD, the block SHALL apply d=0 once per cycle without consuming input, and SHALL go PAD -> OUT when cnt reaches N.
REQ-021 In OUT:
- validArray_0=1.
- dataOutArray_0 = Q.
- dataOutArray_0 SHALL be held stable until nReadyArray_0=1.
REQ-022 OUT -> ACC SHALL occur on the edge where nReadyArray_0=1; on that edge Q=0, QM=all-ones, cnt=0, len_err=0.
REQ-023 Latency: validArray_0 SHALL rise on the edge that accepts the N-th digit, or (N-cnt) edges after an early-last handshake.
REQ-024 Throughput SHALL be at most one word per N+1 cycles; no input digit SHALL be accepted while in OUT or PAD.
REQ-025 pValidArray_0=0 in ACC SHALL stall the block with all state held.
- Gaps of any length between digits SHALL NOT alter the result.
REQ-026 dataOutArray_0 SHALL be driven from registers only; there SHALL be no combinational path from dataInArray_0 to dataOutArray_0.

Reset
REQ-027 On rstn=0, the block SHALL immediately set:
- state=ACC, cnt=0, Q=0, QM=all-ones
- validArray_0=0, len_err=0, dataOutArray_0=0
REQ-028 Reset asserted mid-word (ACC, PAD or OUT) SHALL discard the partial/pending word with no output handshake.
REQ-029 Release of reset SHALL be synchronised internally; the first digit SHALL be accepted no earlier than the second rising edge after rstn deasserts.

Verification
REQ-030 N=16; digits +1, then 15x0, last on digit 16 -> dataOutArray_0=17'h08000, len_err=0, validArray_0 on the 16th handshake edge.
REQ-031 N=16; digits -1, then 15x(+1), last on digit 16 -> 17'h1FFFF (-1 LSB), len_err=0.
REQ-032 N=16; digits +1,+1 with last on digit 2 -> 14 PAD cycles, then 17'h0C000, len_err=1; readyArray_0=0 throughout PAD/OUT.
REQ-033 N=16; 16 digits 2'b11 with no last flag -> 17'h00000, len_err=1.
REQ-034 Random pValidArray_0 gaps plus nReadyArray_0 held low 5 cycles:
- Output stays stable while nReadyArray_0 is low.
- The result matches the golden sum of d_i*2^(16-i).
- The next word starts cleanly after the output handshake.
REQ-035 rstn pulsed low after digit 7 -> outputs cleared at once; the following full word converts correctly, unaffected by the aborted digits.
